// File: rtl/hex_display_mux.sv
// rtl/hex_display_mux.sv - multi-channel seven-segment display controller with auto-scroll, freeze and blanking
// Holds one active-low hex-to-segment decoder per digit behind a registered channel selector.

module SevenSegmentDecoder (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

module hex_display_mux #(
    parameter int NUM_CHANNELS = 4,
    parameter int NUM_DIGITS   = 6,
    parameter int DWELL_CYCLES = 50_000_000
) (
    input  logic                                 CLOCK_50,
    input  logic                                 reset_n,
    input  logic [NUM_CHANNELS*NUM_DIGITS*4-1:0] channel_data,
    input  logic [$clog2(NUM_CHANNELS)-1:0]      sel_channel,
    input  logic                                 auto_mode,
    input  logic                                 freeze,
    input  logic                                 blank_lz,
    output logic [NUM_DIGITS*7-1:0]              hex_out,
    output logic [$clog2(NUM_CHANNELS)-1:0]      active_channel
);

    localparam int CW  = $clog2(NUM_CHANNELS);
    localparam int VW  = 4 * NUM_DIGITS;
    localparam int DCW = $clog2(DWELL_CYCLES);

    localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0]  CHAN_LAST  = CW'(NUM_CHANNELS - 1);
    localparam logic [CW:0]    CHAN_COUNT = (CW + 1)'(NUM_CHANNELS);

    logic [CW-1:0]           chan_idx;
    logic [CW-1:0]           next_chan;
    logic [CW-1:0]           value_chan;
    logic [DCW-1:0]          dwell_cnt;
    logic [DCW-1:0]          next_dwell;
    logic                    freeze_q;
    logic                    hold;
    logic [VW-1:0]           value_reg;
    logic [VW-1:0]           chan_slice;
    logic [NUM_DIGITS*7-1:0] seg_raw;
    logic [NUM_DIGITS*7-1:0] seg_next;
    logic [NUM_DIGITS-1:0]   zero_above;

    // The first high cycle of freeze still captures; only later cycles hold.
    assign hold = freeze & freeze_q;

    always_comb begin
        next_chan  = chan_idx;
        next_dwell = dwell_cnt;
        if (!hold) begin
            if (auto_mode) begin
                if (dwell_cnt == DWELL_LAST) begin
                    next_dwell = '0;
                    next_chan  = (chan_idx == CHAN_LAST) ? '0 : chan_idx + CW'(1);
                end else begin
                    next_dwell = dwell_cnt + DCW'(1);
                end
            end else begin
                next_dwell = '0;
                if ({1'b0, sel_channel} < CHAN_COUNT) begin
                    next_chan = sel_channel;
                end
            end
        end
    end

    always_comb begin
        chan_slice = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (chan_idx == CW'(c)) begin
                chan_slice = channel_data[c*VW +: VW];
            end
        end
    end

    genvar d;
    generate
        for (d = 0; d < NUM_DIGITS; d++) begin : g_digit
            // zero_above[d]: this digit and every more significant one are zero.
            if (d == NUM_DIGITS - 1) begin : g_top
                assign zero_above[d] = (value_reg[d*4 +: 4] == 4'h0);
            end else begin : g_lower
                assign zero_above[d] = zero_above[d+1] & (value_reg[d*4 +: 4] == 4'h0);
            end

            SevenSegmentDecoder u_dec (
                .hex (value_reg[d*4 +: 4]),
                .seg (seg_raw[d*7 +: 7])
            );

            assign seg_next[d*7 +: 7] = (blank_lz && (d != 0) && zero_above[d]) ?
                                        7'h7F : seg_raw[d*7 +: 7];
        end
    endgenerate

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            freeze_q       <= 1'b0;
            chan_idx       <= '0;
            dwell_cnt      <= '0;
            value_reg      <= '0;
            value_chan     <= '0;
            hex_out        <= {NUM_DIGITS{7'h7F}};
            active_channel <= '0;
        end else begin
            freeze_q  <= freeze;
            chan_idx  <= next_chan;
            dwell_cnt <= next_dwell;
            if (!hold) begin
                value_reg  <= chan_slice;
                value_chan <= chan_idx;
            end
            hex_out        <= seg_next;
            active_channel <= value_chan;
        end
    end

endmodule

// File: tb/tb_hex_display_mux.sv
// tb/tb_hex_display_mux.sv - self-checking bench for hex_display_mux
// Covers reset, manual select, auto scroll, freeze, blanking and out-of-range select.

module tb_hex_display_mux;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [95:0] channel_data;
    logic [1:0]  sel_channel;
    logic        auto_mode;
    logic        freeze;
    logic        blank_lz;
    logic [41:0] hex_out;
    logic [1:0]  active_channel;

    logic [71:0] data3;
    logic [1:0]  sel3;
    logic [41:0] hex3;
    logic [1:0]  active3;

    int n_checks = 0;
    int n_fail   = 0;
    int cycles   = 0;

    typedef struct {
        logic [95:0] data;
        logic [1:0]  sel;
        logic        blz;
        logic [41:0] hex;
        logic [1:0]  ch;
    } vec_t;

    typedef struct {
        logic [41:0] hex;
        logic [1:0]  ch;
    } exp_t;

    vec_t  vecs[12];
    exp_t  sb[$];
    logic [41:0] all_seg[4];

    localparam logic [95:0] BASE = {24'h444444, 24'h333333, 24'h222222, 24'h111111};

    hex_display_mux #(.NUM_CHANNELS(4), .NUM_DIGITS(6), .DWELL_CYCLES(4)) dut (
        .CLOCK_50       (clk),
        .reset_n        (reset_n),
        .channel_data   (channel_data),
        .sel_channel    (sel_channel),
        .auto_mode      (auto_mode),
        .freeze         (freeze),
        .blank_lz       (blank_lz),
        .hex_out        (hex_out),
        .active_channel (active_channel)
    );

    hex_display_mux #(.NUM_CHANNELS(3), .NUM_DIGITS(6), .DWELL_CYCLES(4)) dut3 (
        .CLOCK_50       (clk),
        .reset_n        (reset_n),
        .channel_data   (data3),
        .sel_channel    (sel3),
        .auto_mode      (1'b0),
        .freeze         (1'b0),
        .blank_lz       (1'b0),
        .hex_out        (hex3),
        .active_channel (active3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycles <= cycles + 1;
        if (cycles > 20000) begin
            $display("FAIL watchdog: cycles=%0d exceeded limit 20000", cycles);
            $fatal(1);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        all_seg[0] = {6{7'h79}};
        all_seg[1] = {6{7'h24}};
        all_seg[2] = {6{7'h30}};
        all_seg[3] = {6{7'h19}};

        vecs[0]  = '{BASE, 2'd2, 1'b0, {6{7'h30}}, 2'd2};
        vecs[1]  = '{BASE, 2'd3, 1'b0, {6{7'h19}}, 2'd3};
        vecs[2]  = '{BASE, 2'd0, 1'b0, {6{7'h79}}, 2'd0};
        vecs[3]  = '{{24'h444444, 24'h333333, 24'h000A05, 24'h111111}, 2'd1, 1'b1,
                     {7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h12}, 2'd1};
        vecs[4]  = '{{24'h444444, 24'h333333, 24'h000000, 24'h111111}, 2'd1, 1'b1,
                     {{5{7'h7F}}, 7'h40}, 2'd1};
        vecs[5]  = '{{24'h444444, 24'h333333, 24'h000000, 24'h111111}, 2'd1, 1'b0,
                     {6{7'h40}}, 2'd1};
        vecs[6]  = '{{24'h444444, 24'h00012A, 24'h222222, 24'h111111}, 2'd2, 1'b0,
                     {7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h08}, 2'd2};
        vecs[7]  = '{{24'h444444, 24'h00012A, 24'h222222, 24'h111111}, 2'd2, 1'b1,
                     {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h08}, 2'd2};
        vecs[8]  = '{{24'h444444, 24'h333333, 24'h222222, 24'h89ABCD}, 2'd0, 1'b1,
                     {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21}, 2'd0};
        vecs[9]  = '{{24'hFEDCBA, 24'h333333, 24'h222222, 24'h111111}, 2'd3, 1'b1,
                     {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08}, 2'd3};
        vecs[10] = '{{24'h100000, 24'h333333, 24'h222222, 24'h111111}, 2'd3, 1'b1,
                     {7'h79, {5{7'h40}}}, 2'd3};
        vecs[11] = '{{24'h444444, 24'h333333, 24'h222222, 24'h000001}, 2'd0, 1'b1,
                     {{5{7'h7F}}, 7'h79}, 2'd0};

        reset_n      = 1'b0;
        channel_data = {24'h444444, 24'h333333, 24'h222222, 24'h00012A};
        sel_channel  = 2'd0;
        auto_mode    = 1'b0;
        freeze       = 1'b0;
        blank_lz     = 1'b0;
        data3        = {24'h333333, 24'h222222, 24'h111111};
        sel3         = 2'd0;

        // Reset state, then first output two cycles after release
        tick(3);
        check("reset_hex", {22'd0, hex_out}, {22'd0, {6{7'h7F}}});
        check("reset_chan", {62'd0, active_channel}, 64'd0);
        reset_n = 1'b1;
        tick(2);
        check("post_reset_hex", {22'd0, hex_out},
              {22'd0, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h08});
        check("post_reset_chan", {62'd0, active_channel}, 64'd0);

        // Auto scroll from reset with dwell 4
        reset_n      = 1'b0;
        auto_mode    = 1'b1;
        channel_data = BASE;
        tick(1);
        reset_n = 1'b1;
        for (int k = 1; k <= 23; k++) begin
            tick(1);
            if (k >= 2) begin
                check($sformatf("auto_chan_k%0d", k), {62'd0, active_channel},
                      64'(((k - 2) / 4) % 4));
                check($sformatf("auto_hex_k%0d", k), {22'd0, hex_out},
                      {22'd0, all_seg[((k - 2) / 4) % 4]});
            end
        end

        // Freeze raised on the same edge as a dwell wrap
        freeze = 1'b1;
        for (int k = 24; k <= 43; k++) begin
            tick(1);
            channel_data = {$urandom, $urandom, $urandom};
            if (k >= 25) begin
                check($sformatf("freeze_chan_k%0d", k), {62'd0, active_channel}, 64'd1);
                check($sformatf("freeze_hex_k%0d", k), {22'd0, hex_out}, {22'd0, {6{7'h24}}});
            end
        end
        freeze       = 1'b0;
        channel_data = BASE;
        for (int k = 44; k <= 60; k++) begin
            tick(1);
            check($sformatf("resume_chan_k%0d", k), {62'd0, active_channel},
                  64'(((k - 21) / 4) % 4));
            check($sformatf("resume_hex_k%0d", k), {22'd0, hex_out},
                  {22'd0, all_seg[((k - 21) / 4) % 4]});
        end

        // Asynchronous reset mid-scroll
        reset_n = 1'b0;
        #1;
        check("midreset_hex", {22'd0, hex_out}, {22'd0, {6{7'h7F}}});
        check("midreset_chan", {62'd0, active_channel}, 64'd0);
        auto_mode   = 1'b0;
        sel_channel = 2'd0;
        tick(2);
        reset_n = 1'b1;
        tick(3);

        // Manual select table through the scoreboard
        begin
            logic [1:0] prev_ch;
            exp_t       e;
            prev_ch = 2'd0;
            for (int i = 0; i < 12; i++) begin
                channel_data = vecs[i].data;
                sel_channel  = vecs[i].sel;
                blank_lz     = vecs[i].blz;
                sb.push_back('{vecs[i].hex, vecs[i].ch});
                tick(2);
                if (vecs[i].ch != prev_ch)
                    check($sformatf("vec%0d_early_chan", i), {62'd0, active_channel},
                          {62'd0, prev_ch});
                tick(1);
                e = sb.pop_front();
                check($sformatf("vec%0d_hex", i), {22'd0, hex_out}, {22'd0, e.hex});
                check($sformatf("vec%0d_chan", i), {62'd0, active_channel}, {62'd0, e.ch});
                prev_ch = vecs[i].ch;
            end
        end

        // blank_lz change reaches hex_out after one edge
        channel_data = {24'h444444, 24'h333333, 24'h000A05, 24'h111111};
        sel_channel  = 2'd1;
        blank_lz     = 1'b1;
        tick(3);
        check("blz_on_hex", {22'd0, hex_out},
              {22'd0, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h12});
        blank_lz = 1'b0;
        tick(1);
        check("blz_off_hex", {22'd0, hex_out},
              {22'd0, 7'h40, 7'h40, 7'h40, 7'h08, 7'h40, 7'h12});

        // Out-of-range select on the three-channel instance
        sel3 = 2'd1;
        tick(3);
        check("oor_before_chan", {62'd0, active3}, 64'd1);
        sel3 = 2'd3;
        tick(4);
        check("oor_hold_chan", {62'd0, active3}, 64'd1);
        check("oor_hold_hex", {22'd0, hex3}, {22'd0, {6{7'h24}}});
        sel3 = 2'd2;
        tick(3);
        check("oor_after_chan", {62'd0, active3}, 64'd2);
        check("oor_after_hex", {22'd0, hex3}, {22'd0, {6{7'h30}}});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
